// File: rtl/ram_arbiter.sv
// Shares the system RAM ports between the 6502 core, the VGA renderer and the
// UART loader, halting the CPU through RDY while the other two are served.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_we,
  input  logic                  cpu_sync,
  output logic                  cpu_rdy,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_grant,
  output logic                  vid_valid,
  input  logic                  uart_req,
  input  logic                  uart_we,
  input  logic [ADDR_WIDTH-1:0] uart_addr,
  input  logic [DATA_WIDTH-1:0] uart_wdata,
  output logic                  uart_grant,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  output logic [1:0]            owner
);

  typedef enum logic [1:0] {
    SERVE   = 2'd0,
    RESTORE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [15:0]             r_wait_cnt;
  logic                    r_vid_valid;
  logic [ADDR_WIDTH-1:0]   r_addr_last;
  logic                    w_pending;
  logic                    w_forced;
  logic [ADDR_WIDTH-1:0]   w_cpu_a;
  logic                    w_unused_addr;

  assign w_cpu_a       = cpu_addr[ADDR_WIDTH-1:0];
  assign w_unused_addr = ^cpu_addr[15:ADDR_WIDTH];
  assign w_pending     = vid_req | uart_req;
  assign w_forced      = (MAX_WAIT != 0) && (r_wait_cnt == WAIT_LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN: begin
        if (w_pending && (cpu_sync || w_forced))
          w_next = SERVE;
      end
      SERVE: begin
        if (!w_pending)
          w_next = RESTORE;
      end
      RESTORE: begin
        w_next = w_pending ? SERVE : RUN;
      end
      default: w_next = SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SERVE;
      r_wait_cnt  <= '0;
      r_vid_valid <= 1'b0;
      r_addr_last <= '0;
    end else begin
      r_state     <= w_next;
      r_vid_valid <= (r_state == SERVE) & vid_req;
      if (r_state == RUN)
        r_addr_last <= w_cpu_a;
      // Counts only while the CPU keeps running with a request outstanding
      if (r_state == RUN && w_next == RUN && w_pending)
        r_wait_cnt <= r_wait_cnt + 16'd1;
      else
        r_wait_cnt <= '0;
    end
  end

  always_comb begin
    cpu_rdy    = 1'b0;
    vid_grant  = 1'b0;
    uart_grant = 1'b0;
    ram_raddr  = r_addr_last;
    ram_waddr  = r_addr_last;
    ram_wdata  = '0;
    ram_we     = 1'b0;
    unique case (r_state)
      RUN: begin
        cpu_rdy   = 1'b1;
        ram_raddr = w_cpu_a;
        ram_waddr = w_cpu_a;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_we;
      end
      SERVE: begin
        vid_grant  = 1'b1;
        uart_grant = 1'b1;
        ram_raddr  = vid_addr;
        ram_waddr  = uart_addr;
        ram_wdata  = uart_wdata;
        ram_we     = uart_req & uart_we;
      end
      default: begin
      end
    endcase
  end

  assign vid_valid = r_vid_valid;
  assign owner     = r_state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with literal expectations,
// then random traffic checked each cycle against a behavioural model.
module tb_ram_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_we, cpu_sync, cpu_rdy;
  logic          vid_req, vid_grant, vid_valid;
  logic [AW-1:0] vid_addr;
  logic          uart_req, uart_we, uart_grant;
  logic [AW-1:0] uart_addr;
  logic [DW-1:0] uart_wdata;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [1:0]    owner;

  int n_cmp = 0;
  int n_bad = 0;

  // model: phase 0=halted serving, 1=restoring, 2=CPU running
  int            m_phase = 0;
  int            m_waited = 0;
  logic [AW-1:0] m_last = '0;
  logic          m_vv = 1'b0;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_sync(cpu_sync), .cpu_rdy(cpu_rdy),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_grant(vid_grant), .vid_valid(vid_valid),
    .uart_req(uart_req), .uart_we(uart_we),
    .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_grant(uart_grant),
    .ram_raddr(ram_raddr), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram_we(ram_we),
    .owner(owner)
  );

  always #20 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_cmp();
    logic [AW-1:0] ca;
    ca = cpu_addr[AW-1:0];
    chk("owner", owner, m_phase);
    chk("cpu_rdy", cpu_rdy, m_phase == 2);
    chk("vid_grant", vid_grant, m_phase == 0);
    chk("uart_grant", uart_grant, m_phase == 0);
    chk("vid_valid", vid_valid, m_vv);
    case (m_phase)
      2: begin
        chk("run_raddr", ram_raddr, ca);
        chk("run_waddr", ram_waddr, ca);
        chk("run_wdata", ram_wdata, cpu_wdata);
        chk("run_we", ram_we, cpu_we);
      end
      0: begin
        chk("srv_raddr", ram_raddr, vid_addr);
        chk("srv_we", ram_we, uart_req & uart_we);
        chk("srv_waddr", ram_waddr, uart_addr);
        chk("srv_wdata", ram_wdata, uart_wdata);
      end
      default: begin
        chk("rst_raddr", ram_raddr, m_last);
        chk("rst_waddr", ram_waddr, m_last);
        chk("rst_we", ram_we, 0);
      end
    endcase
  endtask

  // compare now, then advance the model across one rising edge
  task automatic tick();
    int  np, nw;
    logic [AW-1:0] nl;
    logic nv;
    bit  pend;
    #1;
    model_cmp();
    pend = vid_req | uart_req;
    np = m_phase; nw = 0; nl = m_last;
    nv = (m_phase == 0) && vid_req;
    if (m_phase == 2) begin
      nl = cpu_addr[AW-1:0];
      if (pend && cpu_sync) np = 0;
      else if (pend && MW != 0 && m_waited + 1 == MW) np = 0;
      else if (pend) nw = m_waited + 1;
    end else if (m_phase == 0) begin
      if (!pend) np = 1;
    end else begin
      np = pend ? 0 : 2;
    end
    if (reset) begin
      np = 0; nw = 0; nl = '0; nv = 1'b0;
    end
    @(posedge clk);
    m_phase = np; m_waited = nw; m_last = nl; m_vv = nv;
    @(negedge clk);
  endtask

  task automatic idle();
    cpu_addr = 16'h0; cpu_wdata = '0; cpu_we = 0; cpu_sync = 0;
    vid_req = 0; vid_addr = '0;
    uart_req = 0; uart_we = 0; uart_addr = '0; uart_wdata = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clk);
    repeat (3) tick();
    #1;
    chk("reset_owner", owner, 0);
    chk("reset_rdy", cpu_rdy, 0);
    chk("reset_vvalid", vid_valid, 0);
    reset = 1'b0;
    tick();
    tick();
    #1 chk("rdy_2nd_edge", cpu_rdy, 1);

    // request during RUN waits for SYNC
    vid_req = 1; vid_addr = 11'h200; cpu_addr = 16'hF0A0;
    tick(); tick();
    cpu_sync = 1;
    #1 chk("rdy_sync_cycle", cpu_rdy, 1);
    tick();
    cpu_sync = 0;
    #1;
    chk("halt_rdy", cpu_rdy, 0);
    chk("vid_grant", vid_grant, 1);
    chk("vid_raddr", ram_raddr, 11'h200);
    tick();
    #1 chk("vid_valid_lat", vid_valid, 1);

    // loader write while serving; CPU write is blocked
    uart_req = 1; uart_we = 1; uart_addr = 11'h123;
    uart_wdata = 8'hA5; cpu_we = 1;
    #1;
    chk("srv_we_lit", ram_we, 1);
    chk("srv_waddr_lit", ram_waddr, 11'h123);
    chk("srv_wdata_lit", ram_wdata, 8'hA5);
    chk("srv_raddr_lit", ram_raddr, 11'h200);
    tick();

    // restore presents the CPU's last read address
    idle();
    tick(); tick();
    cpu_addr = 16'hA955; vid_req = 1; cpu_sync = 1;
    tick();
    idle();
    tick();
    #1;
    chk("restore_raddr", ram_raddr, 11'h155);
    chk("restore_we", ram_we, 0);
    chk("restore_rdy", cpu_rdy, 0);
    tick();
    #1 chk("resume_rdy", cpu_rdy, 1);

    // forced halt after MAX_WAIT pending cycles without SYNC
    vid_req = 1;
    for (int i = 0; i < MW; i++) begin
      #1 chk("wait_rdy", cpu_rdy, 1);
      tick();
    end
    #1 chk("forced_owner", owner, 0);

    // request reasserted in RESTORE, then reset while vid_valid high
    idle();
    tick();
    vid_req = 1;
    #1 chk("restore_owner", owner, 1);
    tick();
    #1 chk("reserve_rdy", cpu_rdy, 0);
    tick();
    #1 chk("vv_before_rst", vid_valid, 1);
    reset = 1;
    tick();
    #1 chk("vv_after_rst", vid_valid, 0);
    reset = 0;
    idle();

    for (int c = 0; c < 4000; c++) begin
      cpu_addr   = 16'($urandom);
      cpu_wdata  = 8'($urandom);
      cpu_we     = 1'($urandom);
      cpu_sync   = ($urandom_range(0, 4) == 0);
      vid_req    = ($urandom_range(0, 3) == 0);
      vid_addr   = 11'($urandom);
      uart_req   = ($urandom_range(0, 5) == 0);
      uart_we    = 1'($urandom);
      uart_addr  = 11'($urandom);
      uart_wdata = 8'($urandom);
      reset      = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
